// File: rtl/tcp_rx_tab_pkg.sv
// Shared types and constants for the RX TCB table request stage.
// State encoding doubles as the debug state field.
package tcp_rx_tab_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } state_e;

  localparam logic [1:0] STS_HIT = 2'd0;
  localparam logic [1:0] STS_BYP = 2'd1;
  localparam logic [1:0] STS_TMO = 2'd2;

  localparam int PD_FID_LSB = 0;
  localparam int PD_FWD_LSB = 16;
  localparam int FID_W      = 16;
  localparam int FWD_W      = 2;

endpackage

// File: rtl/tcp_rx_tab_cell_buf.sv
// Descriptor cell store: PDSZ input cells plus one appended table cell.
// The table cell has its own write port so bypass can clear it alongside the last input cell.
module tcp_rx_tab_cell_buf #(
  parameter int PDWID = 128,
  parameter int PDSZ  = 4,
  parameter int IW    = $clog2(PDSZ + 1)
) (
  input  logic             clk,
  input  logic             cell_we_i,
  input  logic [IW-1:0]    cell_idx_i,
  input  logic [PDWID-1:0] cell_dat_i,
  input  logic             tab_we_i,
  input  logic [PDWID-1:0] tab_dat_i,
  input  logic [IW-1:0]    rd_idx_i,
  output logic [PDWID-1:0] rd_dat_o
);

  logic [PDWID-1:0] mem_q [PDSZ+1];

  always_ff @(posedge clk) begin
    if (cell_we_i) begin
      mem_q[cell_idx_i] <= cell_dat_i;
    end
    if (tab_we_i) begin
      mem_q[PDSZ] <= tab_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_idx_i];

endmodule

// File: rtl/tcp_rx_tab_req.sv
// RX TCB table request stage: collect a descriptor, read the flow's
// table entry (or bypass), then re-emit it with the table cell appended.
module tcp_rx_tab_req
  import tcp_rx_tab_pkg::*;
#(
  parameter int         PDWID       = 128,
  parameter int         PDSZ        = 4,
  parameter int         AWID        = 10,
  parameter int         FID_LSB     = PD_FID_LSB,
  parameter int         FWD_LSB     = PD_FWD_LSB,
  parameter logic [1:0] VAL_FWD_MAC = 2'd1,
  parameter int         DBG_WID     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_pd_vld,
  input  logic [PDWID-1:0]   in_pd_dat,
  output logic               in_pd_rdy,
  output logic               tab_req_vld,
  output logic [AWID-1:0]    tab_req_addr,
  input  logic               tab_req_rdy,
  input  logic               tab_rsp_vld,
  input  logic [PDWID-1:0]   tab_rsp_dat,
  input  logic [15:0]        cfg_rsp_tmo,
  output logic               out_pd_vld,
  output logic [PDWID-1:0]   out_pd_dat,
  input  logic               out_pd_rdy,
  output logic [1:0]         out_tab_sts,
  output logic [DBG_WID-1:0] dbg_sig
);

  localparam int IW = $clog2(PDSZ + 1);
  localparam logic [IW-1:0] LAST_IN  = IW'(PDSZ - 1);
  localparam logic [IW-1:0] LAST_OUT = IW'(PDSZ);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [AWID-1:0]   fid_q;
  logic [FWD_W-1:0]  fwd_q;
  logic [1:0]        sts_q;
  logic [15:0]       tmo_q;
  logic [3:0]        stale_q, stale_d;
  logic              drop_q;
  logic              live_q;

  logic              in_acc;
  logic              out_acc;
  logic              req_acc;
  logic              last_in;
  logic              last_out;
  logic [FWD_W-1:0]  fwd_cur;
  logic              is_byp;
  logic              byp_done;
  logic              rsp_stale;
  logic              rsp_hit;
  logic              tmo_hit;
  logic              tab_we;
  logic [PDWID-1:0]  tab_dat;
  logic [PDWID-1:0]  rd_dat;
  logic [31:0]       dbg_w;

  assign in_acc   = in_pd_vld && in_pd_rdy;
  assign out_acc  = out_pd_vld && out_pd_rdy;
  assign req_acc  = tab_req_vld && tab_req_rdy;
  assign last_in  = idx_q == LAST_IN;
  assign last_out = idx_q == LAST_OUT;

  // With a one-cell descriptor the forward field is still on the bus.
  assign fwd_cur  = (idx_q == '0) ? in_pd_dat[FWD_LSB +: FWD_W] : fwd_q;
  assign is_byp   = fwd_cur == VAL_FWD_MAC;
  assign byp_done = in_acc && last_in && is_byp;

  assign rsp_stale = tab_rsp_vld && (stale_q != 4'd0);
  assign rsp_hit   = tab_rsp_vld && (stale_q == 4'd0) &&
                     (state_q == WAIT);
  assign tmo_hit   = (state_q == WAIT) && !rsp_hit &&
                     (cfg_rsp_tmo != 16'd0) &&
                     (tmo_q == cfg_rsp_tmo - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: begin
        if (in_acc && last_in) begin
          state_d = is_byp ? EMIT : REQ;
        end
      end
      REQ: begin
        if (req_acc) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (rsp_hit || tmo_hit) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_acc && last_out) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_pd_rdy   = 1'b0;
    tab_req_vld = 1'b0;
    out_pd_vld  = 1'b0;
    unique case (state_q)
      COLLECT: in_pd_rdy   = live_q;
      REQ:     tab_req_vld = 1'b1;
      EMIT:    out_pd_vld  = 1'b1;
      default: ;
    endcase
  end

  assign tab_req_addr = tab_req_vld ? fid_q : '0;
  assign out_pd_dat   = out_pd_vld ? rd_dat : '0;
  assign out_tab_sts  = (out_pd_vld && last_out) ? sts_q : STS_HIT;

  always_comb begin
    idx_d = idx_q;
    if (in_acc) begin
      idx_d = last_in ? '0 : idx_q + 1'b1;
    end else if (out_acc) begin
      idx_d = last_out ? '0 : idx_q + 1'b1;
    end
  end

  // A timeout leaves one response in flight that must be swallowed later.
  always_comb begin
    stale_d = stale_q;
    if (rsp_stale && !tmo_hit) begin
      stale_d = stale_q - 4'd1;
    end else if (tmo_hit && !rsp_stale && stale_q != 4'hF) begin
      stale_d = stale_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      fid_q   <= '0;
      fwd_q   <= '0;
      sts_q   <= STS_HIT;
      tmo_q   <= '0;
      stale_q <= '0;
      drop_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      idx_q   <= idx_d;
      stale_q <= stale_d;
      if (in_acc && idx_q == '0) begin
        fid_q <= in_pd_dat[FID_LSB +: AWID];
        fwd_q <= in_pd_dat[FWD_LSB +: FWD_W];
      end
      if (byp_done) begin
        sts_q <= STS_BYP;
      end else if (rsp_hit) begin
        sts_q <= STS_HIT;
      end else if (tmo_hit) begin
        sts_q <= STS_TMO;
      end
      if (req_acc) begin
        tmo_q <= '0;
      end else if (state_q == WAIT && tmo_q != 16'hFFFF) begin
        tmo_q <= tmo_q + 16'd1;
      end
      if (tab_rsp_vld && stale_q == 4'd0 && state_q != WAIT) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign tab_we  = byp_done || rsp_hit || tmo_hit;
  assign tab_dat = rsp_hit ? tab_rsp_dat : '0;

  tcp_rx_tab_cell_buf #(
    .PDWID (PDWID),
    .PDSZ  (PDSZ),
    .IW    (IW)
  ) u_buf (
    .clk        (clk),
    .cell_we_i  (in_acc),
    .cell_idx_i (idx_q),
    .cell_dat_i (in_pd_dat),
    .tab_we_i   (tab_we),
    .tab_dat_i  (tab_dat),
    .rd_idx_i   (idx_q),
    .rd_dat_o   (rd_dat)
  );

  assign dbg_w   = {stale_q, tmo_q[11:0], state_q, 13'h0, drop_q};
  assign dbg_sig = DBG_WID'(dbg_w);

endmodule

// File: tb/tb_tcp_rx_tab_req.sv
// Scoreboard bench for tcp_rx_tab_req: directed descriptors, expected
// output cells queued at issue and checked by an independent monitor.
module tb_tcp_rx_tab_req;
  import tcp_rx_tab_pkg::*;

  localparam int PDWID = 128;
  localparam int AWID  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_pd_vld;
  logic [PDWID-1:0]  in_pd_dat;
  logic              in_pd_rdy;
  logic              tab_req_vld;
  logic [AWID-1:0]   tab_req_addr;
  logic              tab_req_rdy;
  logic              tab_rsp_vld;
  logic [PDWID-1:0]  tab_rsp_dat;
  logic [15:0]       cfg_rsp_tmo;
  logic              out_pd_vld;
  logic [PDWID-1:0]  out_pd_dat;
  logic              out_pd_rdy;
  logic [1:0]        out_tab_sts;
  logic [31:0]       dbg_sig;

  always #5 clk = ~clk;

  tcp_rx_tab_req dut (
    .clk          (clk),
    .rst          (rst),
    .in_pd_vld    (in_pd_vld),
    .in_pd_dat    (in_pd_dat),
    .in_pd_rdy    (in_pd_rdy),
    .tab_req_vld  (tab_req_vld),
    .tab_req_addr (tab_req_addr),
    .tab_req_rdy  (tab_req_rdy),
    .tab_rsp_vld  (tab_rsp_vld),
    .tab_rsp_dat  (tab_rsp_dat),
    .cfg_rsp_tmo  (cfg_rsp_tmo),
    .out_pd_vld   (out_pd_vld),
    .out_pd_dat   (out_pd_dat),
    .out_pd_rdy   (out_pd_rdy),
    .out_tab_sts  (out_tab_sts),
    .dbg_sig      (dbg_sig)
  );

  typedef struct packed {
    logic [127:0] d;
    logic [1:0]   s;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_cell(input logic [7:0] tag,
                                           input int k,
                                           input logic [15:0] fid,
                                           input logic [1:0] fwd);
    logic [127:0] d;
    d = '0;
    d[127:120] = tag;
    d[119:112] = 8'(k);
    if (k == 0) begin
      d[15:0]  = fid;
      d[17:16] = fwd;
    end else begin
      d[31:0] = 32'hDEAD_0000 | 32'(k);
    end
    return d;
  endfunction

  task automatic push_exp(input logic [7:0] tag, input logic [15:0] fid,
                          input logic [1:0] fwd, input logic [127:0] tabd,
                          input logic [1:0] sts);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.d = mk_cell(tag, k, fid, fwd);
      e.s = STS_HIT;
      exp_q.push_back(e);
    end
    e.d = tabd;
    e.s = sts;
    exp_q.push_back(e);
  endtask

  task automatic put_cell(input logic [127:0] d);
    int n;
    n = 0;
    in_pd_vld = 1'b1;
    in_pd_dat = d;
    forever begin
      @(negedge clk);
      if (in_pd_rdy || n > 200) break;
      n++;
    end
    chk("in_rdy_bound", 1'(n <= 200), 1'b1);
    @(posedge clk);
    #1;
    in_pd_vld = 1'b0;
    in_pd_dat = '0;
  endtask

  task automatic send_desc(input logic [7:0] tag, input logic [15:0] fid,
                           input logic [1:0] fwd);
    for (int k = 0; k < 4; k++) begin
      put_cell(mk_cell(tag, k, fid, fwd));
    end
  endtask

  // Wait for the request, optionally stall it, then accept it.
  task automatic wait_req(input logic [9:0] addr, input int hold,
                          output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!tab_req_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk("req_vld", tab_req_vld, 1'b1);
    chk("req_addr", tab_req_addr, addr);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("req_hold_vld", tab_req_vld, 1'b1);
      chk("req_hold_addr", tab_req_addr, addr);
    end
    tab_req_rdy = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rsp_at(input int c, input logic [127:0] d);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
    tab_rsp_vld = 1'b1;
    tab_rsp_dat = d;
    @(posedge clk);
    #1;
    tab_rsp_vld = 1'b0;
    tab_rsp_dat = '0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_in_rdy"}, in_pd_rdy, 1'b0);
    chk({nm, "_req_vld"}, tab_req_vld, 1'b0);
    chk({nm, "_req_addr"}, tab_req_addr, '0);
    chk({nm, "_out_vld"}, out_pd_vld, 1'b0);
    chk({nm, "_out_dat"}, out_pd_dat, '0);
    chk({nm, "_out_sts"}, out_tab_sts, '0);
    chk({nm, "_dbg"}, dbg_sig, '0);
  endtask

  // Monitor: pop/compare on each accepted cell, check stability under stall.
  initial begin
    logic         hold_pend;
    logic [127:0] hold_dat;
    exp_t         e;
    hold_pend = 1'b0;
    hold_dat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("out_hold_vld", out_pd_vld, 1'b1);
          chk("out_hold_dat", out_pd_dat, hold_dat);
        end
        if (out_pd_vld && out_pd_rdy) begin
          if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL out_unexpected: got %0h want none", out_pd_dat);
          end else begin
            e = exp_q.pop_front();
            chk("out_dat", out_pd_dat, e.d);
            chk("out_sts", out_tab_sts, e.s);
          end
        end
        hold_pend = out_pd_vld && !out_pd_rdy;
        hold_dat  = out_pd_dat;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    rst         = 1'b1;
    in_pd_vld   = 1'b0;
    in_pd_dat   = '0;
    tab_req_rdy = 1'b1;
    tab_rsp_vld = 1'b0;
    tab_rsp_dat = '0;
    cfg_rsp_tmo = 16'd0;
    out_pd_rdy  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table hit, response in WAIT cycle 3
    push_exp(8'h11, 16'h0123, 2'd0, 128'hA5, STS_HIT);
    send_desc(8'h11, 16'h0123, 2'd0);
    wait_req(10'h123, 0, lat);
    chk("hit_req_lat", lat, 0);
    rsp_at(3, 128'hA5);
    @(negedge clk);
    chk("hit_out_lat", out_pd_vld, 1'b1);
    drain("hit_drain");
    chk("hit_drop_bit", dbg_sig[0], 1'b0);

    // MAC forward bypass
    push_exp(8'h22, 16'h0007, 2'd1, 128'h0, STS_BYP);
    send_desc(8'h22, 16'h0007, 2'd1);
    @(negedge clk);
    chk("byp_out_lat", out_pd_vld, 1'b1);
    chk("byp_no_req", tab_req_vld, 1'b0);
    drain("byp_drain");

    // Timeout after 8 cycles, late response later swallowed
    cfg_rsp_tmo = 16'd8;
    push_exp(8'h33, 16'h0200, 2'd0, 128'h0, STS_TMO);
    send_desc(8'h33, 16'h0200, 2'd0);
    wait_req(10'h200, 0, lat);
    n = 0;
    @(negedge clk);
    while (!out_pd_vld && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 8);
    chk("tmo_stale_cnt", dbg_sig[31:28], 4'd1);
    drain("tmo_drain");
    cfg_rsp_tmo = 16'd0;
    push_exp(8'h44, 16'h03FF, 2'd0, 128'h55, STS_HIT);
    send_desc(8'h44, 16'h03FF, 2'd0);
    wait_req(10'h3FF, 0, lat);
    rsp_at(1, 128'hBAD);
    @(negedge clk);
    chk("late_stale_cnt", dbg_sig[31:28], 4'd0);
    chk("late_no_emit", out_pd_vld, 1'b0);
    rsp_at(1, 128'h55);
    drain("late_drain");
    chk("late_drop_bit", dbg_sig[0], 1'b0);

    // Request backpressure, then output toggled every cycle
    tab_req_rdy = 1'b0;
    push_exp(8'h55, 16'h02AB, 2'd0, 128'hCAFE, STS_HIT);
    send_desc(8'h55, 16'h02AB, 2'd0);
    wait_req(10'h2AB, 5, lat);
    out_pd_rdy = 1'b0;
    rsp_at(0, 128'hCAFE);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
      out_pd_rdy = ~out_pd_rdy;
    end
    out_pd_rdy = 1'b1;
    drain("bp_drain");

    // Response coincides with timeout: response wins
    cfg_rsp_tmo = 16'd4;
    push_exp(8'h66, 16'h0055, 2'd0, 128'h77, STS_HIT);
    send_desc(8'h66, 16'h0055, 2'd0);
    wait_req(10'h055, 0, lat);
    rsp_at(3, 128'h77);
    @(negedge clk);
    chk("coin_out_lat", out_pd_vld, 1'b1);
    chk("coin_stale_cnt", dbg_sig[31:28], 4'd0);
    drain("coin_drain");

    // Leave a stale count behind, then reset mid-WAIT
    cfg_rsp_tmo = 16'd3;
    push_exp(8'h77, 16'h0011, 2'd0, 128'h0, STS_TMO);
    send_desc(8'h77, 16'h0011, 2'd0);
    wait_req(10'h011, 0, lat);
    drain("tmo3_drain");
    chk("tmo3_stale_cnt", dbg_sig[31:28], 4'd1);
    cfg_rsp_tmo = 16'd0;
    send_desc(8'h88, 16'h0010, 2'd0);
    wait_req(10'h010, 0, lat);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("rst_wait");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-EMIT
    out_pd_rdy = 1'b0;
    send_desc(8'h89, 16'h0009, 2'd1);
    @(negedge clk);
    chk("emit_before_rst", out_pd_vld, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("rst_emit");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_pd_rdy = 1'b1;

    // Normal descriptor after reset
    push_exp(8'h99, 16'h0321, 2'd0, 128'h1234, STS_HIT);
    send_desc(8'h99, 16'h0321, 2'd0);
    wait_req(10'h321, 0, lat);
    rsp_at(0, 128'h1234);
    drain("post_rst_drain");

    // Unsolicited response in COLLECT sets the sticky drop bit
    tab_rsp_vld = 1'b1;
    tab_rsp_dat = 128'hF00;
    @(posedge clk);
    #1;
    tab_rsp_vld = 1'b0;
    @(negedge clk);
    chk("drop_bit", dbg_sig[0], 1'b1);
    chk("drop_in_rdy", in_pd_rdy, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
